// File: rtl/qam16_pkg.sv
// Shared QAM16 receive-path definitions: symbol/byte widths, Gray constellation
// levels (common with the demapper) and the nibble-packer state encoding.
package qam16_pkg;

  localparam int SYM_W  = 4;
  localparam int BYTE_W = 8;

  // Per-axis Gray code for amplitude levels -3, -1, +1, +3
  localparam logic [1:0] GRAY_M3 = 2'b00;
  localparam logic [1:0] GRAY_M1 = 2'b01;
  localparam logic [1:0] GRAY_P1 = 2'b11;
  localparam logic [1:0] GRAY_P3 = 2'b10;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } pack_state_t;

  function automatic logic [BYTE_W-1:0] pack_byte(input logic [SYM_W-1:0] first,
                                                  input logic [SYM_W-1:0] second,
                                                  input logic             msb_first);
    return msb_first ? {first, second} : {second, first};
  endfunction

endpackage

// File: rtl/qam16_nibble_packer_if.sv
// Byte stream with valid/ready backpressure leaving the nibble packer.
interface qam16_nibble_packer_if;
  import qam16_pkg::*;

  logic [BYTE_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tlast;

  modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
  modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);

endinterface

// File: rtl/byte_fifo.sv
// First-word-fall-through FIFO; a push while full is accepted only if a pop
// frees a slot in the same cycle.
module byte_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign level = wr_ptr - rd_ptr;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (wr_ptr == rd_ptr);
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;

  // Gate the head so the output reads zero while nothing is queued
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/qam16_nibble_packer.sv
// Packs demapped QAM16 nibbles into framed bytes behind a FWFT FIFO; drops and
// flags bytes when the FIFO is full because the demapper cannot be stalled.
//
// state    | meaning
// ST_EMPTY | no nibble held
// ST_HALF  | first nibble of the next byte held in hold_q
module qam16_nibble_packer
  import qam16_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int FRAME_BYTES = 64,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [SYM_W-1:0]              din,
  input  logic                          wren,
  input  logic                          flush,
  qam16_nibble_packer_if.master         m,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow
);

  localparam int CNT_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BYTES - 1);

  pack_state_t       state;
  logic [SYM_W-1:0]  hold_q;
  logic [CNT_W-1:0]  byte_cnt;

  logic              push;
  logic [BYTE_W-1:0] push_byte;
  logic              push_last;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [BYTE_W:0]   fifo_rdata;
  logic              cnt_last;

  assign cnt_last = (byte_cnt == CNT_LAST);

  always_comb begin
    push      = 1'b0;
    push_byte = '0;
    push_last = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (wren && flush) begin
          push      = 1'b1;
          push_byte = pack_byte(din, '0, MSB_FIRST);
          push_last = 1'b1;
        end
      end
      ST_HALF: begin
        if (wren) begin
          push      = 1'b1;
          push_byte = pack_byte(hold_q, din, MSB_FIRST);
          push_last = cnt_last | flush;
        end else if (flush) begin
          push      = 1'b1;
          push_byte = pack_byte(hold_q, '0, MSB_FIRST);
          push_last = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_EMPTY;
      hold_q   <= '0;
      byte_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: if (wren && !flush) begin
          hold_q <= din;
          state  <= ST_HALF;
        end
        ST_HALF: if (wren || flush) state <= ST_EMPTY;
        default: state <= ST_EMPTY;
      endcase

      // Count push attempts, dropped ones included, so framing follows the symbols
      if (flush)     byte_cnt <= '0;
      else if (push) byte_cnt <= cnt_last ? '0 : byte_cnt + 1'b1;

      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  assign pop = m.m_tvalid & m.m_tready;

  byte_fifo #(
    .WIDTH (BYTE_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .wdata ({push_last, push_byte}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign m.m_tvalid = ~fifo_empty;
  assign m.m_tlast  = fifo_rdata[BYTE_W];
  assign m.m_tdata  = fifo_rdata[BYTE_W-1:0];

endmodule

// File: doc/qam16_nibble_packer.md
# qam16_nibble_packer

Packs the 4-bit Gray-decoded symbols produced by the QAM16 demapper into bytes, frames them, and presents them on a byte stream with valid/ready backpressure. It sits directly downstream of the demapper, which has no backpressure, and upstream of the receive DMA/descrambler. An internal FIFO absorbs downstream stalls. Overruns are reported rather than silently stalling the demapper.

## Interface
- FIFO_DEPTH, 16, byte FIFO entries; power of two, ≥ 2
- FRAME_BYTES, 64, bytes per frame; m_tlast on the last byte; ≥ 1
- MSB_FIRST, 1, 1: first nibble becomes byte[7:4]; 0: first nibble becomes byte[3:0]

Ports (clock and reset first):
- clk  in  1  single clock for all logic
- rstn  in  1  asynchronous, active-low reset
- din  in  4  demapped symbol, qualified by wren
- wren  in  1  symbol strobe (demapper rdout); one nibble per high cycle; no backpressure
- flush  in  1  one-cycle pulse: end the current frame early
- m_tdata  out  8  output byte
- m_tvalid  out  1  m_tdata/m_tlast valid
- m_tready  in  1  downstream accept
- m_tlast  out  1  last byte of frame
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: a byte was dropped because the FIFO was full

## Operation
- Packer FSM states:
  - EMPTY: no nibble held.
  - HALF: nibble held in hold_q.
- EMPTY with wren: hold_q <= din; go to HALF.
- HALF with wren:
  - Form the byte: {hold_q,din} if MSB_FIRST, else {din,hold_q}.
  - Push {last,byte} into the FIFO; go to EMPTY.
- Frame counter byte_cnt, range 0..FRAME_BYTES-1:
  - Counts push attempts.
  - last = (byte_cnt == FRAME_BYTES-1); byte_cnt wraps to 0 on that push.
- flush:
  - flush in EMPTY, no wren: no push; byte_cnt <= 0.
  - flush in EMPTY with wren: push the byte padded with 4'b0000 in the second-nibble position, last=1; byte_cnt <= 0; stay EMPTY.
  - flush in HALF, no wren: push hold_q padded with 4'b0000, last=1; byte_cnt <= 0; go to EMPTY.
  - flush in HALF with wren: push the normal byte with last forced to 1; byte_cnt <= 0.
- FIFO:
  - First-word-fall-through, 9 bits wide ({last,data}).
  - Pop on m_tvalid & m_tready.
- Push when full:
  - Push with no pop in the same cycle: byte dropped; overflow <= 1; byte_cnt still advances, so framing stays aligned to the symbol count.
  - Push and pop in the same cycle while full: push accepted; level unchanged.
- overflow clears only on reset.

## Timing
- Reset values:
  - m_tvalid = 0, m_tlast = 0, m_tdata = 0, level = 0, overflow = 0.
  - FSM in EMPTY; byte_cnt = 0; FIFO pointers = 0.
- Latency: completing nibble (or flush) strobe in cycle N with the FIFO empty → m_tvalid = 1 with that byte in cycle N+1.
- level updates in the cycle after a push or pop. Push and pop in the same cycle leave level unchanged.
- m_tdata/m_tlast stay stable while m_tvalid & !m_tready.
- Back-to-back wren every cycle sustains 1 byte per 2 cycles. The output drains at up to 1 byte per cycle.
- Reset asserted mid-frame discards the held nibble, the FIFO contents and byte_cnt immediately (asynchronous). The first nibble after release starts a new frame.

## Structure
- Shared package qam16_pkg:
  - SYM_W = 4 and BYTE_W = 8.
  - Gray-code constellation constants, shared with the demapper.
  - Packer FSM state enum.
- Sub-module byte_fifo:
  - Parameterised width and depth; synchronous FWFT.
  - Async active-low reset; full/empty/level outputs.
- Packer FSM and frame counter stay in the top module.

## Test plan
- MSB_FIRST=1, FRAME_BYTES=4, m_tready=1; nibbles 0xA,0x5,0x3,0xC,0x1,0x2,0xF,0xE,0x7,0x8 → bytes 0xA5,0x3C,0x12,0xFE,0x78; m_tlast only on 0xFE; 0x78 has last=0.
- MSB_FIRST=0; nibbles 0xA,0x5 → 0x5A.
- Nibble 0x9 then flush alone → 0x90 with last=1. The next frame's byte_cnt restarts: the 4th byte after it carries last (FRAME_BYTES=4).
- FIFO_DEPTH=4, m_tready=0, 12 nibbles → level saturates at 4; overflow=1 after the 5th byte; m_tready=1 → bytes 1-4 drain unchanged.
- Full FIFO, push and pop in the same cycle → level stays 4; overflow stays 0.
- rstn pulsed low while in HALF with 3 bytes queued → m_tvalid=0, level=0 immediately. Nibbles 0x1,0x2 after release → 0x12.
